// File: rtl/pattern_matcher_n.sv
// Serial pattern detector: SIPO program/mask/window registers, a tolerance compare,
// an arming FSM that demands a full fresh window after reload, and a saturating hit counter.
module pattern_matcher_n #(
  parameter int unsigned WIDTH = 512,
  parameter int unsigned TOL   = 0,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rnot,
  input  logic             prgm_en,
  input  logic             prgm,
  input  logic             mask_en,
  input  logic             mask,
  input  logic             sig_valid,
  input  logic             sig,
  input  logic             clr_hits,
  output logic             armed,
  output logic             match,
  output logic             match_pulse,
  output logic [CNT_W-1:0] hit_count
);

  localparam int unsigned MW = $clog2(WIDTH + 1);
  localparam int unsigned FW = $clog2(WIDTH);

  typedef enum logic [1:0] {StIdle, StLoad, StFill, StArmed} state_e;

  state_e            state_q;
  logic [WIDTH-1:0]  prog_q;
  logic [WIDTH-1:0]  mask_q;
  logic [WIDTH-1:0]  win_q;
  logic [FW-1:0]     fill_q;
  logic              match_q;
  logic              pulse_q;
  logic [CNT_W-1:0]  hit_q;

  logic [WIDTH-1:0]  diff;
  logic [MW-1:0]     mism;
  logic              load;
  logic              match_d;

  assign load = prgm_en | mask_en;
  assign diff = (prog_q ^ win_q) & mask_q;

  always_comb begin
    mism = '0;
    for (int i = 0; i < WIDTH; i++) begin
      mism = mism + MW'(diff[i]);
    end
  end

  // A reload in progress suppresses the match in the same cycle.
  assign match_d = (state_q == StArmed) && (32'(mism) <= TOL) && !load;

  always_ff @(posedge clk or negedge rnot) begin
    if (!rnot) begin
      prog_q  <= '0;
      mask_q  <= '1;
      win_q   <= '0;
      fill_q  <= '0;
      state_q <= StIdle;
      match_q <= 1'b0;
      pulse_q <= 1'b0;
      hit_q   <= '0;
    end else begin
      if (prgm_en)   prog_q <= {prog_q[WIDTH-2:0], prgm};
      if (mask_en)   mask_q <= {mask_q[WIDTH-2:0], mask};
      if (sig_valid) win_q  <= {win_q[WIDTH-2:0], sig};

      match_q <= match_d;
      pulse_q <= match_d & ~match_q;

      if (clr_hits) begin
        hit_q <= '0;
      end else if (pulse_q && (hit_q != '1)) begin
        hit_q <= hit_q + CNT_W'(1);
      end

      if (load) begin
        state_q <= StLoad;
        fill_q  <= '0;
      end else begin
        case (state_q)
          StIdle: state_q <= StIdle;
          StLoad: begin
            state_q <= StFill;
            fill_q  <= '0;
          end
          StFill: begin
            if (sig_valid) begin
              if (fill_q == FW'(WIDTH - 1)) begin
                state_q <= StArmed;
                fill_q  <= '0;
              end else begin
                fill_q <= fill_q + FW'(1);
              end
            end
          end
          StArmed: state_q <= StArmed;
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  assign armed       = (state_q == StArmed);
  assign match       = match_q;
  assign match_pulse = pulse_q;
  assign hit_count   = hit_q;

endmodule

// File: tb/tb_pattern_matcher_n.sv
// Bench for pattern_matcher_n: two WIDTH=8 instances (exact/16-bit counter and TOL=1/2-bit
// counter) share stimulus; a cycle model feeds a scoreboard and hand vectors pin key timing.
module tb_pattern_matcher_n;

  localparam int MIdle = 0, MLoad = 1, MFill = 2, MArmed = 3;

  logic clk = 1'b0;
  logic rnot = 1'b0;
  logic prgm_en = 1'b0, prgm = 1'b0, mask_en = 1'b0, mask = 1'b0;
  logic sig_valid = 1'b0, sig = 1'b0, clr_hits = 1'b0;
  logic armed0, match0, pulse0;
  logic [15:0] hit0;
  logic armed1, match1, pulse1;
  logic [1:0] hit1;

  always #5 clk = ~clk;

  pattern_matcher_n #(.WIDTH(8), .TOL(0), .CNT_W(16)) u_dut0 (
    .clk(clk), .rnot(rnot), .prgm_en(prgm_en), .prgm(prgm), .mask_en(mask_en), .mask(mask),
    .sig_valid(sig_valid), .sig(sig), .clr_hits(clr_hits), .armed(armed0), .match(match0),
    .match_pulse(pulse0), .hit_count(hit0)
  );

  pattern_matcher_n #(.WIDTH(8), .TOL(1), .CNT_W(2)) u_dut1 (
    .clk(clk), .rnot(rnot), .prgm_en(prgm_en), .prgm(prgm), .mask_en(mask_en), .mask(mask),
    .sig_valid(sig_valid), .sig(sig), .clr_hits(clr_hits), .armed(armed1), .match(match1),
    .match_pulse(pulse1), .hit_count(hit1)
  );

  typedef struct {
    logic a;
    logic m0;
    logic p0;
    int   h0;
    logic m1;
    logic p1;
    int   h1;
  } exp_t;

  typedef struct {
    logic pe, p, me, m, sv, s, clr;
    logic ea, em, ep;
    int   eh;
  } vec_t;

  exp_t exp_q[$];
  vec_t vecs[$];

  int checks = 0;
  int failures = 0;

  logic [7:0] m_prog, m_mask, m_win;
  int m_st, m_fill, m_hit0, m_hit1;
  logic m_match0, m_pulse0, m_match1, m_pulse1;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, req);
    end
  endtask

  task automatic model_reset();
    m_prog = 8'h00; m_mask = 8'hFF; m_win = 8'h00;
    m_st = MIdle; m_fill = 0; m_hit0 = 0; m_hit1 = 0;
    m_match0 = 1'b0; m_pulse0 = 1'b0; m_match1 = 1'b0; m_pulse1 = 1'b0;
  endtask

  // One clock: drive inputs, predict outputs after the edge, then compare.
  task automatic step(input logic pe, p, me, m, sv, s, clr);
    exp_t e;
    int   mism;
    bit   ld, nm0, nm1;
    prgm_en = pe; prgm = p; mask_en = me; mask = m;
    sig_valid = sv; sig = s; clr_hits = clr;
    ld = pe | me;
    mism = 0;
    for (int i = 0; i < 8; i++) if (m_mask[i] && (m_prog[i] != m_win[i])) mism++;
    nm0 = (m_st == MArmed) && (mism == 0) && !ld;
    nm1 = (m_st == MArmed) && (mism <= 1) && !ld;
    if (clr) m_hit0 = 0; else if (m_pulse0 && m_hit0 < 65535) m_hit0++;
    if (clr) m_hit1 = 0; else if (m_pulse1 && m_hit1 < 3) m_hit1++;
    m_pulse0 = nm0 && !m_match0; m_match0 = nm0;
    m_pulse1 = nm1 && !m_match1; m_match1 = nm1;
    if (ld) begin
      m_st = MLoad; m_fill = 0;
    end else if (m_st == MLoad) begin
      m_st = MFill;
    end else if (m_st == MFill && sv) begin
      if (m_fill == 7) m_st = MArmed; else m_fill++;
    end
    if (pe) m_prog = {m_prog[6:0], p};
    if (me) m_mask = {m_mask[6:0], m};
    if (sv) m_win = {m_win[6:0], s};
    e.a = (m_st == MArmed); e.m0 = m_match0; e.p0 = m_pulse0; e.h0 = m_hit0;
    e.m1 = m_match1; e.p1 = m_pulse1; e.h1 = m_hit1;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      check("sb_empty", 0, 1);
    end else begin
      e = exp_q.pop_front();
      check("sb_armed0", int'(armed0), int'(e.a));
      check("sb_armed1", int'(armed1), int'(e.a));
      check("sb_match0", int'(match0), int'(e.m0));
      check("sb_pulse0", int'(pulse0), int'(e.p0));
      check("sb_hit0", int'(hit0), e.h0);
      check("sb_match1", int'(match1), int'(e.m1));
      check("sb_pulse1", int'(pulse1), int'(e.p1));
      check("sb_hit1", int'(hit1), e.h1);
    end
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic stream(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, v[i], 1'b0);
  endtask

  task automatic load_byte(input logic [7:0] pv, input logic [7:0] mv, input logic dp, dm);
    for (int i = 7; i >= 0; i--) step(dp, pv[i], dm, mv[i], 1'b0, 1'b0, 1'b0);
  endtask

  function automatic void add(input logic pe, p, me, m, sv, s, clr, ea, em, ep, input int eh);
    vec_t v;
    v.pe = pe; v.p = p; v.me = me; v.m = m; v.sv = sv; v.s = s; v.clr = clr;
    v.ea = ea; v.em = em; v.ep = ep; v.eh = eh;
    vecs.push_back(v);
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] pat;
    pat = 8'hB2;
    model_reset();
    #12;
    check("rst_armed0", int'(armed0), 0);
    check("rst_match0", int'(match0), 0);
    check("rst_pulse0", int'(pulse0), 0);
    check("rst_hit0", int'(hit0), 0);
    check("rst_match1", int'(match1), 0);
    rnot = 1'b1;

    // Unloaded: window equals program but nothing arms.
    for (int i = 0; i < 20; i++) add(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    for (int i = 7; i >= 0; i--) add(1, pat[i], 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 7; i >= 0; i--) add(0, 0, 0, 0, 1, pat[i], 0, logic'(i == 0), 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0);
    add(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 1);
    add(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 1);
    foreach (vecs[k]) begin
      step(vecs[k].pe, vecs[k].p, vecs[k].me, vecs[k].m, vecs[k].sv, vecs[k].s, vecs[k].clr);
      check("vec_armed", int'(armed0), int'(vecs[k].ea));
      check("vec_match", int'(match0), int'(vecs[k].em));
      check("vec_pulse", int'(pulse0), int'(vecs[k].ep));
      check("vec_hit", int'(hit0), vecs[k].eh);
    end

    // Tolerance: one mismatch accepted by TOL=1 only, two rejected.
    stream(8'hB3); idle();
    check("tol_b3_m1", int'(match1), 1);
    check("tol_b3_m0", int'(match0), 0);
    stream(8'hB1); idle();
    check("tol_b1_m1", int'(match1), 0);
    stream(8'hB2); idle();
    check("tol_b2_p0", int'(pulse0), 1);
    check("tol_b2_p1", int'(pulse1), 1);
    idle();
    check("tol_hit0", int'(hit0), 2);
    check("tol_hit1_sat", int'(hit1), 3);

    // Care mask: low nibble ignored.
    load_byte(8'hA5, 8'hF0, 1'b1, 1'b1); idle();
    stream(8'hAC); idle();
    check("mask_ac", int'(match0), 1);
    stream(8'h2C); idle();
    check("mask_2c", int'(match0), 0);
    stream(8'hAC); idle();
    check("mask_ac2_pulse", int'(pulse0), 1);

    // Reload while matched clears armed/match on the same edge.
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("rl_armed", int'(armed0), 0);
    check("rl_match", int'(match0), 0);
    check("rl_pulse", int'(pulse0), 0);
    idle();
    for (int i = 0; i < 7; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    check("rl_7bits", int'(armed0), 0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    check("rl_8bits", int'(armed0), 1);

    // Asynchronous reset mid-FILL.
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    idle();
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    #2;
    rnot = 1'b0;
    #1;
    check("arst_armed", int'(armed0), 0);
    check("arst_match", int'(match0), 0);
    check("arst_pulse", int'(pulse0), 0);
    check("arst_hit0", int'(hit0), 0);
    check("arst_hit1", int'(hit1), 0);
    model_reset();
    @(posedge clk);
    #1;
    rnot = 1'b1;

    // Counter saturation and clear priority.
    load_byte(8'h00, 8'h00, 1'b1, 1'b0); idle();
    stream(8'h00); idle();
    for (int i = 0; i < 4; i++) begin
      stream(8'hFF); stream(8'h00); idle();
    end
    idle();
    check("cnt_hit0_5", int'(hit0), 5);
    check("cnt_hit1_sat", int'(hit1), 3);
    stream(8'hFF); stream(8'h00); idle();
    check("clr_pulse", int'(pulse0), 1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("clr_hit0", int'(hit0), 0);
    check("clr_hit1", int'(hit1), 0);
    idle();
    check("clr_hold", int'(hit0), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
